// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: serialising load/store unit that turns one CU memory request into a valid/ready bus access.
module lsu_mem_stage #(
  parameter int TIMEOUT = 256,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [7:0]        wmask,
  input  logic [7:0]        rmask,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  input  logic              mem_resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rdata,
  output logic              out_err
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          ld;
  logic [1:0]    off;
  logic          half, word, fault, no_access, timed_out;
  assign in_ready      = state == IDLE;
  assign mem_req_valid = state == REQ;
  assign out_valid     = state == DONE;
  // Access size comes from wmask for stores and rmask for loads.
  always_comb begin
    half      = is_store ? (wmask == 8'h03 || wmask == 8'h0c) : rmask == 8'h02;
    word      = is_store ? wmask == 8'hff : rmask == 8'hff;
    fault     = (is_load & is_store) |
                ((is_load | is_store) & ((half & addr[0]) | (word & |addr[1:0]) | (is_store & ~|wmask)));
    no_access = fault | ~(is_load | is_store);
    timed_out = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ld            <= 1'b0;
      off           <= 2'b00;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      out_rdata     <= '0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ld            <= is_load;
          off           <= addr[1:0];
          out_rdata     <= '0;
          out_err       <= fault;
          mem_req_we    <= is_store;
          mem_req_addr  <= {addr[ADDR_W-1:2], 2'b00};
          mem_req_wdata <= is_store ? wdata << {addr[1:0], 3'b000} : '0;
          mem_req_wstrb <= is_store ? (wmask == 8'hff ? 4'hf : wmask[3:0]) : 4'h0;
          state         <= no_access ? DONE : REQ;
        end
        REQ: if (mem_req_ready) begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_resp_valid) begin
            state     <= DONE;
            out_rdata <= ld ? mem_resp_rdata >> {off, 3'b000} : '0;
            out_err   <= mem_resp_err;
          end else if (timed_out) begin
            state   <= DONE;
            out_err <= 1'b1;
          end
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized transactions checked against a size/alignment reference model.
module tb_lsu_mem_stage;
  localparam int TO = 8;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 0, in_ready, is_load = 0, is_store = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [7:0]  wmask = 0, rmask = 0;
  logic        mem_req_valid, mem_req_ready = 0, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 0, mem_resp_err = 0;
  logic [31:0] mem_resp_rdata = 0;
  logic        out_valid, out_ready = 0, out_err;
  logic [31:0] out_rdata;
  int checks = 0, failures = 0;

  lsu_mem_stage #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .addr(addr), .wdata(wdata),
    .wmask(wmask), .rmask(rmask), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_err(mem_resp_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_we", mem_req_we, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wdata", mem_req_wdata, 0);
    chk("rst_req_wstrb", mem_req_wstrb, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_out_err", out_err, 0);
  endtask

  // rdly: cycles mem_req_ready stays low; sdly: WAIT cycles before response (>= TO means none); odly: out_ready stall
  task automatic run(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] wd,
                     input logic [7:0] wm, input logic [7:0] rm, input int rdly, input int sdly,
                     input logic [31:0] rd, input logic rerr, input int odly);
    int sz;
    logic ferr, skip, eerr;
    logic [31:0] er, ewd;
    logic [3:0] es;
    sz   = st ? (wm == 8'hff ? 4 : (wm == 8'h03 || wm == 8'h0c) ? 2 : 1)
              : (rm == 8'hff ? 4 : rm == 8'h02 ? 2 : 1);
    ferr = (ld && st) || ((ld || st) && ((st && wm == 8'h00) || (a % sz != 0)));
    skip = ferr || !(ld || st);
    ewd  = wd << (8 * (a % 4));
    es   = wm == 8'hff ? 4'hf : wm[3:0];
    er   = 0;
    eerr = ferr;
    chk("accept_ready", in_ready, 1);
    in_valid = 1; is_load = ld; is_store = st; addr = a; wdata = wd; wmask = wm; rmask = rm;
    step();
    in_valid = 0; is_load = 1'($urandom); is_store = 1'($urandom); addr = $urandom;
    wdata = $urandom; wmask = 8'($urandom); rmask = 8'($urandom);
    if (skip) begin
      chk("fast_done", out_valid, 1);
      chk("no_bus", mem_req_valid, 0);
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_busy", out_valid, 0);
        chk("req_we", mem_req_we, st);
        chk("req_addr", mem_req_addr, a & ~32'h3);
        if (st) begin
          chk("req_wdata", mem_req_wdata, ewd);
          chk("req_wstrb", mem_req_wstrb, es);
        end
        mem_req_ready = (i == rdly);
        step();
      end
      mem_req_ready = 0;
      for (int i = 0; i < sdly && i < TO; i++) begin
        chk("wait_busy", out_valid, 0);
        chk("wait_noreq", mem_req_valid, 0);
        mem_resp_rdata = $urandom;
        step();
      end
      if (sdly < TO) begin
        mem_resp_valid = 1; mem_resp_rdata = rd; mem_resp_err = rerr;
        step();
        mem_resp_valid = 0; mem_resp_err = 0;
        er   = ld ? rd >> (8 * (a % 4)) : 0;
        eerr = rerr;
      end else eerr = 1;
    end
    for (int i = 0; i <= odly; i++) begin
      chk("done_valid", out_valid, 1);
      chk("done_rdata", out_rdata, er);
      chk("done_err", out_err, eerr);
      chk("done_no_accept", in_ready, 0);
      out_ready = (i == odly);
      step();
    end
    out_ready = 0;
    chk("idle_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] wtab [8];
    logic [7:0] rtab [3];
    int k;
    wtab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h03, 8'h0c, 8'hff, 8'h00};
    rtab = '{8'h01, 8'h02, 8'hff};
    #2 chk_reset_vals();
    step(); rst_n = 1; step();
    run(1, 0, 32'h80000010, 0, 0, 8'hff, 0, 0, 32'h12345678, 0, 0);
    run(0, 1, 32'h80000003, 32'h000000ab, 8'h08, 0, 0, 0, 32'hffffffff, 0, 0);
    run(1, 0, 32'h80000002, 0, 0, 8'h02, 3, 1, 32'hbeef1234, 0, 0);
    run(1, 0, 32'h80000001, 0, 0, 8'hff, 0, 0, 0, 0, 0);
    run(1, 0, 32'h80000004, 0, 0, 8'hff, 0, TO, 32'hdeadbeef, 0, 0);
    mem_resp_valid = 1; mem_resp_rdata = 32'hdeadbeef; mem_req_ready = 1;
    step();
    mem_resp_valid = 0; mem_req_ready = 0;
    chk("late_resp_dropped", out_valid, 0);
    chk("late_resp_idle", in_ready, 1);
    chk("idle_ready_ignored", mem_req_valid, 0);
    run(1, 0, 32'h8000000d, 0, 0, 8'h01, 1, TO - 1, 32'h11223344, 1, 5);
    run(1, 1, 32'h80000000, 0, 8'hff, 8'hff, 0, 0, 0, 0, 0);
    run(0, 0, 32'h80000000, 0, 8'hff, 8'hff, 0, 0, 0, 0, 1);
    run(0, 1, 32'h80000001, 32'h1234, 8'h03, 0, 0, 0, 0, 0, 0);
    run(0, 1, 32'h80000000, 32'h1234, 8'h00, 0, 0, 0, 0, 0, 0);
    run(0, 1, 32'h80000002, 32'h5678, 8'h0c, 0, 2, 2, 0, 1, 0);
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 11);
      run(k < 5 || k == 10, (k >= 5 && k < 10) || k == 10, $urandom, $urandom,
          wtab[$urandom_range(0, 7)], rtab[$urandom_range(0, 2)],
          $urandom_range(0, 3), $urandom_range(0, 9), $urandom, 1'($urandom_range(0, 3) == 0),
          $urandom_range(0, 2));
    end
    in_valid = 1; is_load = 1; is_store = 0; addr = 32'h80000020; rmask = 8'hff;
    step();
    in_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("pre_reset_wait", mem_req_addr, 32'h80000020);
    #2 rst_n = 0;
    #1 chk_reset_vals();
    step(); rst_n = 1; step();
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_valid", out_valid, 0);
    run(1, 0, 32'h80000021, 0, 0, 8'h01, 0, 0, 32'haabbccdd, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
